// File: rtl/nibble_pkg.sv
// nibble_pkg: shared types and constants for the nibble pair loader
package nibble_pkg;
  localparam int NIB_W = 4;
  localparam int PAIR_W = 2 * NIB_W;
  localparam int DEPTH_DEFAULT = 4;
  typedef enum logic {PH_A, PH_B} phase_t;
  typedef struct packed {
    logic [NIB_W-1:0] a;
    logic [NIB_W-1:0] b;
  } pair_t;
endpackage

// File: rtl/nibble_pair_loader_sync_fifo.sv
// sync_fifo: first-word-fallthrough FIFO; full and empty are told apart by count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign pop_data = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage is left unreset; stale words are masked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/nibble_pair_loader.sv
// nibble_pair_loader: pairs consecutive nibbles as {A,B} and buffers the pairs for the adder
module nibble_pair_loader #(
  parameter int NIB_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W-1:0]       in_nib,
  input  logic                   clear_half,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*NIB_W-1:0]     out_pair,
  output logic [$clog2(DEPTH):0] count,
  output logic                   half_pending
);
  import nibble_pkg::*;
  phase_t phase;
  logic [NIB_W-1:0] hold;
  logic [2*NIB_W-1:0] pop_data;
  logic full, empty, accept, push, pop;
  assign in_ready = !clear_half & (phase == PH_A | !full);
  assign accept = in_valid & in_ready;
  assign push = accept & (phase == PH_B);
  assign pop = out_valid & out_ready;
  assign out_valid = !empty;
  assign out_pair = empty ? '0 : pop_data;
  assign half_pending = phase == PH_B;
  // pairing FSM: A is parked in hold until its B arrives; clear_half drops it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= PH_A;
      hold <= '0;
    end else if (clear_half) begin
      phase <= PH_A;
      hold <= '0;
    end else if (accept) begin
      phase <= phase == PH_A ? PH_B : PH_A;
      if (phase == PH_A) hold <= in_nib;
    end
  end
  sync_fifo #(.WIDTH(2 * NIB_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({hold, in_nib}),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );
endmodule

// File: tb/tb_nibble_pair_loader.sv
// tb_nibble_pair_loader: directed scoreboard bench for the nibble pair loader
module tb_nibble_pair_loader;
  import nibble_pkg::*;
  logic clk = 0, reset = 1, in_valid = 0, clear_half = 0, out_ready = 0;
  logic [3:0] in_nib = '0;
  logic in_ready, out_valid, half_pending;
  logic [7:0] out_pair;
  logic [2:0] count;
  int errors = 0, checks = 0;
  pair_t q[$];
  phase_t m_phase = PH_A;
  logic [3:0] m_hold = '0;

  nibble_pair_loader #(.NIB_W(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_nib(in_nib), .clear_half(clear_half), .out_valid(out_valid),
    .out_ready(out_ready), .out_pair(out_pair), .count(count),
    .half_pending(half_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic er);
    pair_t hd;
    if (q.size() != 0) hd = q[0]; else hd = '0;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_pair", 32'(out_pair), 32'(hd));
    chk("count", 32'(count), 32'(q.size()));
    chk("half_pending", 32'(half_pending), 32'(m_phase == PH_B));
  endtask

  task automatic cyc(input logic iv, input logic [3:0] nib, input logic ch, input logic ordy);
    logic er, acc;
    in_valid = iv; in_nib = nib; clear_half = ch; out_ready = ordy;
    #1;
    er = !ch && (m_phase == PH_A || q.size() < 4);
    check_outputs(er);
    acc = iv && er;
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (ch) m_phase = PH_A;
    else if (acc) begin
      if (m_phase == PH_A) begin
        m_hold = nib;
        m_phase = PH_B;
      end else begin
        q.push_back({m_hold, nib});
        m_phase = PH_A;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_outputs(1'b1);
    @(negedge clk);
    reset = 0;
    cyc(1, 4'h3, 0, 0);
    cyc(1, 4'h5, 0, 0);
    cyc(0, 4'h0, 0, 0);
    cyc(0, 4'h0, 0, 1);
    for (int i = 1; i <= 8; i++) cyc(1, 4'(i), 0, 0);
    cyc(1, 4'h9, 0, 0);
    cyc(1, 4'ha, 0, 0);
    repeat (4) cyc(0, 4'h0, 0, 1);
    cyc(0, 4'h0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(1, 4'($urandom_range(15)), 0, 1);
    repeat (2) cyc(0, 4'h0, 0, 1);
    cyc(1, 4'h9, 0, 0);
    cyc(1, 4'h0, 1, 0);
    cyc(1, 4'ha, 0, 0);
    cyc(1, 4'hb, 0, 0);
    repeat (2) cyc(0, 4'h0, 0, 1);
    for (int i = 8; i >= 1; i--) cyc(1, 4'(i + 4), 0, 0);
    cyc(1, 4'h2, 0, 0);
    cyc(1, 4'hc, 0, 1);
    cyc(1, 4'hc, 0, 0);
    cyc(0, 4'h0, 0, 0);
    repeat (5) cyc(0, 4'h0, 0, 1);
    for (int i = 1; i <= 5; i++) cyc(1, 4'(i), 0, 0);
    check_outputs(1'b1);
    reset = 1;
    #1;
    q.delete();
    m_phase = PH_A;
    check_outputs(1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    cyc(1, 4'h6, 0, 0);
    cyc(1, 4'h7, 0, 0);
    cyc(0, 4'h0, 0, 1);
    cyc(0, 4'h0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
